// File: rtl/pmp_arbiter.sv
// pmp_arbiter: shares one PMP checker port between PMP CSR writes,
// instruction-fetch checks and load/store checks. One transaction is in
// flight at a time. CSR writes always win. IF and LS are arbitrated
// round-robin or with fixed IF priority, depending on RR_EN.
module pmp_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  priv_mode,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    input  logic [1:0]  if_req_size,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_req_addr,
    input  logic [1:0]  ls_req_size,
    input  logic [1:0]  ls_req_oper,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [1:0]  if_rsp_perm,
    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic [1:0]  ls_rsp_perm,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [31:0] csr_req_addr,
    input  logic [31:0] csr_req_wdata,
    output logic        pmp_wr_en,
    output logic [31:0] pmp_rw_addr,
    output logic [31:0] pmp_wdata,
    output logic [1:0]  pmp_oper,
    output logic [1:0]  pmp_size,
    output logic [1:0]  pmp_priv_mode,
    output logic [31:0] pmp_addr,
    input  logic [1:0]  pmp_permission
);

    localparam logic [1:0] OPER_EXEC   = 2'b10;
    localparam logic [1:0] OPER_BYPASS = 2'b11;

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, RESP} state_t;

    state_t     state_reg, state_next;
    logic       last_ls_reg;    // 1: the most recent IF/LS grant went to LS
    logic       owner_ls_reg;   // 1: the transaction in flight belongs to LS
    logic [1:0] perm_reg;       // permission returned to the requester
    logic       if_wins;
    logic       csr_hs, if_hs, ls_hs, ls_bypass;

    // State register; reset drops any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Arbitration, handshakes, next state and response strobes
    always_comb begin
        state_next    = state_reg;
        csr_req_ready = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_rsp_valid  = 1'b0;
        ls_rsp_valid  = 1'b0;
        // IF takes a tie unless it was the last one served (round-robin)
        if_wins = RR_EN ? (!ls_req_valid || last_ls_reg) : 1'b1;

        if (!reset && state_reg == IDLE) begin
            if (csr_req_valid) begin
                csr_req_ready = 1'b1;
            end else if (if_req_valid && if_wins) begin
                if_req_ready = 1'b1;
            end else if (ls_req_valid) begin
                ls_req_ready = 1'b1;
            end
        end

        csr_hs    = csr_req_valid && csr_req_ready;
        if_hs     = if_req_valid && if_req_ready;
        ls_hs     = ls_req_valid && ls_req_ready;
        ls_bypass = ls_hs && (ls_req_oper == OPER_BYPASS);

        case (state_reg)
            IDLE: begin
                if (csr_hs) begin
                    state_next = WRITE;
                end else if (if_hs) begin
                    state_next = CHECK;
                end else if (ls_hs) begin
                    state_next = ls_bypass ? RESP : CHECK;
                end
            end
            WRITE: state_next = IDLE;
            CHECK: state_next = RESP;
            RESP: begin
                if_rsp_valid = !owner_ls_reg;
                ls_rsp_valid = owner_ls_reg;
                if (owner_ls_reg ? ls_rsp_ready : if_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Checker-port registers, arbitration history and captured permission
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pmp_wr_en     <= 1'b0;
            pmp_rw_addr   <= '0;
            pmp_wdata     <= '0;
            pmp_oper      <= 2'b00;
            pmp_size      <= 2'b00;
            pmp_priv_mode <= 2'b00;
            pmp_addr      <= '0;
            perm_reg      <= 2'b00;
            last_ls_reg   <= 1'b1;
            owner_ls_reg  <= 1'b0;
        end else begin
            // write strobe lasts exactly the WRITE cycle
            pmp_wr_en <= csr_hs;
            if (csr_hs) begin
                pmp_rw_addr <= csr_req_addr;
                pmp_wdata   <= csr_req_wdata;
            end
            if (if_hs) begin
                pmp_addr      <= if_req_addr;
                pmp_size      <= if_req_size;
                pmp_oper      <= OPER_EXEC;
                pmp_priv_mode <= priv_mode;
                last_ls_reg   <= 1'b0;
                owner_ls_reg  <= 1'b0;
            end
            if (ls_hs) begin
                last_ls_reg  <= 1'b1;
                owner_ls_reg <= 1'b1;
                // oper 11 never reaches the checker, so its port keeps its value
                if (!ls_bypass) begin
                    pmp_addr      <= ls_req_addr;
                    pmp_size      <= ls_req_size;
                    pmp_oper      <= ls_req_oper;
                    pmp_priv_mode <= priv_mode;
                end
            end
            if (state_reg == CHECK) begin
                perm_reg <= pmp_permission;
            end else if (ls_bypass) begin
                perm_reg <= 2'b00;
            end
        end
    end

    assign if_rsp_perm = perm_reg;
    assign ls_rsp_perm = perm_reg;

endmodule

// File: tb/tb_pmp_arbiter.sv
// tb_pmp_arbiter: directed scenarios followed by random traffic. A
// transaction-level reference model predicts which request is granted
// and what each grant produces next: a write cycle, a check cycle, or a
// response held until accepted.
module tb_pmp_arbiter;

    localparam int PH_W = 1;
    localparam int PH_C = 2;
    localparam int PH_R = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  priv_mode = 2'b00;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_req_addr = '0;
    logic [1:0]  if_req_size = '0;
    logic        ls_req_valid = 1'b0, ls_req_ready;
    logic [31:0] ls_req_addr = '0;
    logic [1:0]  ls_req_size = '0, ls_req_oper = '0;
    logic        if_rsp_valid, if_rsp_ready = 1'b0;
    logic [1:0]  if_rsp_perm;
    logic        ls_rsp_valid, ls_rsp_ready = 1'b0;
    logic [1:0]  ls_rsp_perm;
    logic        csr_req_valid = 1'b0, csr_req_ready;
    logic [31:0] csr_req_addr = '0, csr_req_wdata = '0;
    logic        pmp_wr_en;
    logic [31:0] pmp_rw_addr, pmp_wdata, pmp_addr;
    logic [1:0]  pmp_oper, pmp_size, pmp_priv_mode;
    logic [1:0]  pmp_permission = 2'b00;

    // fixed-priority instance: IF and LS both always requesting
    logic        if0_req_ready, ls0_req_ready, csr0_req_ready;
    logic        if0_rsp_valid, ls0_rsp_valid, pmp0_wr_en;
    logic [1:0]  if0_rsp_perm, ls0_rsp_perm, pmp0_oper, pmp0_size, pmp0_priv_mode;
    logic [31:0] pmp0_rw_addr, pmp0_wdata, pmp0_addr;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          ph_q[$];
    logic        m_last_ls = 1'b1;
    logic        m_owner_ls = 1'b0;
    logic [1:0]  m_perm = 2'b00;
    logic [31:0] exp_rw_addr = '0, exp_wdata = '0, exp_addr = '0;
    logic [1:0]  exp_oper = '0, exp_size = '0, exp_priv = '0;
    logic        acc_if = 1'b0, acc_ls = 1'b0, acc_csr = 1'b0;

    // observation logs for directed scenarios
    int grant_log[$];
    int g0_log[$];
    int wr_cnt = 0;
    int csr_rdy_cnt = 0;
    int cyc = 0;
    bit win0 = 1'b0;

    pmp_arbiter #(.RR_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .priv_mode(priv_mode),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_req_size(if_req_size),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_req_addr(ls_req_addr), .ls_req_size(ls_req_size), .ls_req_oper(ls_req_oper),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_perm(if_rsp_perm),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_perm(ls_rsp_perm),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
        .pmp_wr_en(pmp_wr_en), .pmp_rw_addr(pmp_rw_addr), .pmp_wdata(pmp_wdata),
        .pmp_oper(pmp_oper), .pmp_size(pmp_size), .pmp_priv_mode(pmp_priv_mode),
        .pmp_addr(pmp_addr), .pmp_permission(pmp_permission)
    );

    pmp_arbiter #(.RR_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .priv_mode(2'b00),
        .if_req_valid(1'b1), .if_req_ready(if0_req_ready),
        .if_req_addr(32'h0000_1000), .if_req_size(2'b10),
        .ls_req_valid(1'b1), .ls_req_ready(ls0_req_ready),
        .ls_req_addr(32'h0000_2000), .ls_req_size(2'b10), .ls_req_oper(2'b00),
        .if_rsp_valid(if0_rsp_valid), .if_rsp_ready(1'b1), .if_rsp_perm(if0_rsp_perm),
        .ls_rsp_valid(ls0_rsp_valid), .ls_rsp_ready(1'b1), .ls_rsp_perm(ls0_rsp_perm),
        .csr_req_valid(1'b0), .csr_req_ready(csr0_req_ready),
        .csr_req_addr(32'h0), .csr_req_wdata(32'h0),
        .pmp_wr_en(pmp0_wr_en), .pmp_rw_addr(pmp0_rw_addr), .pmp_wdata(pmp0_wdata),
        .pmp_oper(pmp0_oper), .pmp_size(pmp0_size), .pmp_priv_mode(pmp0_priv_mode),
        .pmp_addr(pmp0_addr), .pmp_permission(2'b01)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set just after the falling edge.
    task automatic cycle();
        int g;
        int front;
        #1;
        g = 0;
        front = (ph_q.size() == 0) ? 0 : ph_q[0];
        if (front == 0) begin
            if (csr_req_valid) g = 1;
            else if (if_req_valid && (!ls_req_valid || m_last_ls)) g = 2;
            else if (ls_req_valid) g = 3;
        end
        chk("csr_ready", csr_req_ready, (g == 1));
        chk("if_ready", if_req_ready, (g == 2));
        chk("ls_ready", ls_req_ready, (g == 3));
        chk("pmp_wr_en", pmp_wr_en, (front == PH_W));
        chk("if_rsp_valid", if_rsp_valid, (front == PH_R && !m_owner_ls));
        chk("ls_rsp_valid", ls_rsp_valid, (front == PH_R && m_owner_ls));
        if (front == PH_R && !m_owner_ls) chk("if_rsp_perm", if_rsp_perm, m_perm);
        if (front == PH_R && m_owner_ls) chk("ls_rsp_perm", ls_rsp_perm, m_perm);
        chk("pmp_rw_addr", pmp_rw_addr, exp_rw_addr);
        chk("pmp_wdata", pmp_wdata, exp_wdata);
        chk("pmp_addr", pmp_addr, exp_addr);
        chk("pmp_oper", pmp_oper, exp_oper);
        chk("pmp_size", pmp_size, exp_size);
        chk("pmp_priv_mode", pmp_priv_mode, exp_priv);
        if (if_req_valid && if_req_ready) grant_log.push_back(2);
        if (ls_req_valid && ls_req_ready) grant_log.push_back(3);
        if (pmp_wr_en) wr_cnt++;
        if (csr_req_ready) csr_rdy_cnt++;
        if (win0) begin
            chk("rr0_ls_ready", ls0_req_ready, 1'b0);
            if (if0_req_ready) g0_log.push_back(cyc);
        end
        if (front == PH_C) m_perm = pmp_permission;
        acc_csr = (g == 1);
        acc_if  = (g == 2);
        acc_ls  = (g == 3);
        @(posedge clock);
        cyc++;
        if (front == PH_W || front == PH_C) void'(ph_q.pop_front());
        else if (front == PH_R && (m_owner_ls ? ls_rsp_ready : if_rsp_ready)) void'(ph_q.pop_front());
        case (g)
            1: begin
                ph_q.push_back(PH_W);
                exp_rw_addr = csr_req_addr;
                exp_wdata   = csr_req_wdata;
            end
            2: begin
                ph_q.push_back(PH_C);
                ph_q.push_back(PH_R);
                m_owner_ls = 1'b0;
                m_last_ls  = 1'b0;
                exp_addr = if_req_addr;
                exp_size = if_req_size;
                exp_oper = 2'b10;
                exp_priv = priv_mode;
            end
            3: begin
                m_owner_ls = 1'b1;
                m_last_ls  = 1'b1;
                if (ls_req_oper == 2'b11) begin
                    ph_q.push_back(PH_R);
                    m_perm = 2'b00;
                end else begin
                    ph_q.push_back(PH_C);
                    ph_q.push_back(PH_R);
                    exp_addr = ls_req_addr;
                    exp_size = ls_req_size;
                    exp_oper = ls_req_oper;
                    exp_priv = priv_mode;
                end
            end
            default: ;
        endcase
        @(negedge clock);
    endtask

    // Asynchronous reset pulse starting between clock edges
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        chk("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
        chk("rst_pmp_wr_en", pmp_wr_en, 1'b0);
        chk("rst_pmp_addr", pmp_addr, 32'h0);
        chk("rst_pmp_rw_addr", pmp_rw_addr, 32'h0);
        chk("rst_pmp_wdata", pmp_wdata, 32'h0);
        chk("rst_pmp_oper", pmp_oper, 2'b00);
        chk("rst_pmp_size", pmp_size, 2'b00);
        chk("rst_pmp_priv", pmp_priv_mode, 2'b00);
        chk("rst_ready", {csr_req_ready, if_req_ready, ls_req_ready}, 3'b000);
        ph_q.delete();
        m_last_ls = 1'b1;
        exp_rw_addr = '0; exp_wdata = '0; exp_addr = '0;
        exp_oper = '0; exp_size = '0; exp_priv = '0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready_held", {csr_req_ready, if_req_ready, ls_req_ready}, 3'b000);
        reset = 1'b0;
    endtask

    task automatic new_if();
        if_req_addr = $urandom;
        if_req_size = 2'($urandom_range(0, 3));
    endtask

    task automatic new_ls(input logic [1:0] oper);
        ls_req_addr = $urandom;
        ls_req_size = 2'($urandom_range(0, 3));
        ls_req_oper = oper;
    endtask

    initial begin
        // reset state, with requests pending so ready gating is visible
        csr_req_valid = 1'b1;
        if_req_valid  = 1'b1;
        @(negedge clock);
        do_reset();
        csr_req_valid = 1'b0;

        // round-robin tie from reset: IF, LS, IF, LS
        ls_req_valid = 1'b1;
        new_if();
        new_ls(2'($urandom_range(0, 2)));
        if_rsp_ready = 1'b1;
        ls_rsp_ready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 12; i++) begin
            pmp_permission = 2'($urandom_range(0, 3));
            priv_mode = 2'($urandom_range(0, 2));
            cycle();
            if (acc_if) new_if();
            if (acc_ls) new_ls(2'($urandom_range(0, 2)));
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        chk("rr_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_grant_order", grant_log[i], (i % 2 == 0) ? 2 : 3);

        // CSR write: valid held through the write cycle, granted once
        wr_cnt = 0;
        csr_rdy_cnt = 0;
        csr_req_valid = 1'b1;
        csr_req_addr  = 32'h0000_03A0;
        csr_req_wdata = 32'h0000_000F;
        cycle();
        cycle();
        csr_req_valid = 1'b0;
        cycle();
        cycle();
        chk("csr_wr_pulses", wr_cnt, 1);
        chk("csr_ready_cycles", csr_rdy_cnt, 1);
        chk("csr_rw_addr", pmp_rw_addr, 32'h0000_03A0);
        chk("csr_wdata", pmp_wdata, 32'h0000_000F);

        // LS oper 11 bypasses the checker
        pmp_permission = 2'b11;
        ls_req_valid = 1'b1;
        new_ls(2'b11);
        cycle();
        ls_req_valid = 1'b0;
        cycle();
        cycle();

        // response stalled; a CSR write must wait for the response handshake
        if_req_valid = 1'b1;
        new_if();
        if_rsp_ready = 1'b0;
        cycle();
        if_req_valid = 1'b0;
        csr_req_valid = 1'b1;
        csr_req_addr  = 32'h0000_03B0;
        csr_req_wdata = $urandom;
        csr_rdy_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            pmp_permission = 2'($urandom_range(0, 3));
            cycle();
        end
        chk("stall_csr_blocked", csr_rdy_cnt, 0);
        if_rsp_ready = 1'b1;
        cycle();
        cycle();
        csr_req_valid = 1'b0;
        cycle();
        cycle();
        chk("stall_csr_granted", csr_rdy_cnt, 1);

        // reset while the checker is busy: no response afterwards
        if_req_valid = 1'b1;
        new_if();
        cycle();
        if_req_valid = 1'b0;
        csr_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        do_reset();
        csr_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // random traffic; the fixed-priority instance is observed meanwhile
        win0 = 1'b1;
        acc_if = 1'b0;
        acc_ls = 1'b0;
        acc_csr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!if_req_valid || acc_if) begin
                if_req_valid = ($urandom_range(0, 2) == 0);
                new_if();
            end
            if (!ls_req_valid || acc_ls) begin
                ls_req_valid = ($urandom_range(0, 2) == 0);
                new_ls(2'($urandom_range(0, 3)));
            end
            if (!csr_req_valid || acc_csr) begin
                csr_req_valid = ($urandom_range(0, 7) == 0);
                csr_req_addr  = $urandom;
                csr_req_wdata = $urandom;
            end
            if_rsp_ready   = $urandom_range(0, 1) != 0;
            ls_rsp_ready   = $urandom_range(0, 1) != 0;
            pmp_permission = 2'($urandom_range(0, 3));
            priv_mode      = 2'($urandom_range(0, 2));
            cycle();
        end
        win0 = 1'b0;
        chk("rr0_grants_seen", (g0_log.size() > 100), 1'b1);
        for (int i = 1; i < g0_log.size(); i++) chk("rr0_gap", g0_log[i] - g0_log[i-1], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
